// File: rtl/mem_responder_pkg.sv
// Shared constants and types for the mem_responder memory slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_responder_pkg;

    // Word width shared with the core's data path.
    localparam int DATA_WIDTH_DEF = 16;

    // Legal range of the read pipeline depth.
    localparam int RD_LATENCY_MIN = 1;
    localparam int RD_LATENCY_MAX = 4;

    // Width of the accepted-read / accepted-write counters.
    localparam int CNT_WIDTH = 16;

    typedef logic [CNT_WIDTH-1:0] cnt_t;

    // Which port currently owns the array.
    typedef enum logic {
        SRC_CORE = 1'b0,
        SRC_HOST = 1'b1
    } src_sel_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic cnt_t sat_inc(input cnt_t v);
        return (v == '1) ? v : v + cnt_t'(1);
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Core memory port, host preload port and status outputs of mem_responder.
// Latency: n/a (wiring only).
// Backpressure: none; requests are sampled every cycle, o_mem_busy flags drops.
interface mem_responder_if
    import mem_responder_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH_LOG2 = 8
);
    // Core port
    logic [DATA_WIDTH-1:0] i_mem_addr;
    logic [DATA_WIDTH-1:0] i_mem_w_data;
    logic                  i_mem_r_en;
    logic                  i_mem_w_en;
    logic [DATA_WIDTH-1:0] o_mem_r_data;
    logic                  o_mem_r_valid;
    logic                  o_mem_busy;

    // Host port
    logic                  i_host_en;
    logic [DEPTH_LOG2-1:0] i_host_addr;
    logic [DATA_WIDTH-1:0] i_host_w_data;
    logic                  i_host_w_en;
    logic                  i_host_r_en;

    // Statistics
    logic [CNT_WIDTH-1:0]  o_rd_count;
    logic [CNT_WIDTH-1:0]  o_wr_count;

    modport master (
        output i_mem_addr, i_mem_w_data, i_mem_r_en, i_mem_w_en,
        output i_host_en, i_host_addr, i_host_w_data, i_host_w_en, i_host_r_en,
        input  o_mem_r_data, o_mem_r_valid, o_mem_busy, o_rd_count, o_wr_count
    );

    modport slave (
        input  i_mem_addr, i_mem_w_data, i_mem_r_en, i_mem_w_en,
        input  i_host_en, i_host_addr, i_host_w_data, i_host_w_en, i_host_r_en,
        output o_mem_r_data, o_mem_r_valid, o_mem_busy, o_rd_count, o_wr_count
    );

endinterface

// File: rtl/mem_rd_pipe.sv
// Read-return shift register: carries captured read data with a valid bit.
// Latency: RD_LATENCY cycles from in_vld to out_vld.
// Backpressure: none; advances every cycle, one entry per cycle.
module mem_rd_pipe
    import mem_responder_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int RD_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_vld,
    input  logic [DATA_WIDTH-1:0] in_dat,
    output logic                  out_vld,
    output logic [DATA_WIDTH-1:0] out_dat
);

    logic [RD_LATENCY-1:0] vld_q;
    logic [DATA_WIDTH-1:0] dat_q [RD_LATENCY];

    // Stage 0 captures the new read; later stages shift toward the output. Reset drops everything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= in_vld;
            dat_q[0] <= in_dat;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign out_vld = vld_q[RD_LATENCY-1];
    assign out_dat = dat_q[RD_LATENCY-1];

endmodule

// File: rtl/mem_responder.sv
// Word array answering core or host reads/writes, with saturating request counters.
// Latency: reads return RD_LATENCY cycles after sampling; writes land at the sampling edge.
// Backpressure: none; while the host owns the array, core requests are silently dropped.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH_LOG2 = 8,
    parameter int RD_LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    mem_responder_if.slave   bus
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    // Storage is deliberately not reset so a preloaded image survives a core reset.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    src_sel_t              src_sel;
    logic [DEPTH_LOG2-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_w_dat;
    logic                  req_w_en;
    logic                  req_r_en;
    logic [DATA_WIDTH-1:0] rd_dat;
    cnt_t                  rd_cnt_q;
    cnt_t                  wr_cnt_q;

    // Upper core address bits wrap and are intentionally dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.i_mem_addr[DATA_WIDTH-1:DEPTH_LOG2];

    assign src_sel = bus.i_host_en ? SRC_HOST : SRC_CORE;

    // Pick the request source; the unselected port has no effect at all.
    always_comb begin
        req_addr  = bus.i_mem_addr[DEPTH_LOG2-1:0];
        req_w_dat = bus.i_mem_w_data;
        req_w_en  = bus.i_mem_w_en;
        req_r_en  = bus.i_mem_r_en;
        if (src_sel == SRC_HOST) begin
            req_addr  = bus.i_host_addr;
            req_w_dat = bus.i_host_w_data;
            req_w_en  = bus.i_host_w_en;
            req_r_en  = bus.i_host_r_en;
        end
    end

    // Write-first: each port carries one address, so a simultaneous write always targets the word being read.
    always_comb begin
        rd_dat = req_w_en ? req_w_dat : mem_q[req_addr];
    end

    // Array update at the sampling edge.
    always_ff @(posedge clk) begin
        if (req_w_en) begin
            mem_q[req_addr] <= req_w_dat;
        end
    end

    // Count accepted requests, sticking at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            if (req_r_en) rd_cnt_q <= sat_inc(rd_cnt_q);
            if (req_w_en) wr_cnt_q <= sat_inc(wr_cnt_q);
        end
    end

    mem_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .RD_LATENCY (RD_LATENCY)
    ) u_rd_pipe (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (req_r_en),
        .in_dat  (rd_dat),
        .out_vld (bus.o_mem_r_valid),
        .out_dat (bus.o_mem_r_data)
    );

    assign bus.o_mem_busy = bus.i_host_en;
    assign bus.o_rd_count = rd_cnt_q;
    assign bus.o_wr_count = wr_cnt_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed vectors, per-cycle reference model, literal pins.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_responder;
    import mem_responder_pkg::*;

    localparam int DW  = 16;
    localparam int DL  = 8;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_responder_if #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL)) bus ();

    mem_responder #(
        .DATA_WIDTH (DW),
        .DEPTH_LOG2 (DL),
        .RD_LATENCY (LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] pat(input int i);
        return 16'(i * 257) ^ 16'h5A00;
    endfunction

    function automatic logic [15:0] sat16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Reference model: words, counters and a list of reads with the cycle they must appear.
    typedef struct {
        logic [15:0] dat;
        int          due;
    } exp_rd_t;

    exp_rd_t     pend[$];
    logic [15:0] mem_m [256];
    logic [15:0] m_rd_cnt = 16'd0;
    logic [15:0] m_wr_cnt = 16'd0;
    int          cyc = 0;

    // Compare at each falling edge, then predict the effect of the coming rising edge.
    initial begin
        logic [7:0]  a;
        logic [15:0] wd;
        logic        we;
        logic        re;
        logic        exp_v;
        exp_rd_t     e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                pend.delete();
                m_rd_cnt = 16'd0;
                m_wr_cnt = 16'd0;
                check("rst_r_valid", 32'(bus.o_mem_r_valid), 32'd0);
                check("rst_r_data", 32'(bus.o_mem_r_data), 32'd0);
                check("rst_rd_count", 32'(bus.o_rd_count), 32'd0);
                check("rst_wr_count", 32'(bus.o_wr_count), 32'd0);
            end else begin
                exp_v = (pend.size() > 0) && (pend[0].due == cyc);
                check("m_r_valid", 32'(bus.o_mem_r_valid), 32'(exp_v));
                if (exp_v) begin
                    check("m_r_data", 32'(bus.o_mem_r_data), 32'(pend[0].dat));
                    void'(pend.pop_front());
                end
                check("m_rd_count", 32'(bus.o_rd_count), 32'(m_rd_cnt));
                check("m_wr_count", 32'(bus.o_wr_count), 32'(m_wr_cnt));
                check("m_busy", 32'(bus.o_mem_busy), 32'(bus.i_host_en));
                if (bus.i_host_en) begin
                    a  = bus.i_host_addr;
                    wd = bus.i_host_w_data;
                    we = bus.i_host_w_en;
                    re = bus.i_host_r_en;
                end else begin
                    a  = bus.i_mem_addr[7:0];
                    wd = bus.i_mem_w_data;
                    we = bus.i_mem_w_en;
                    re = bus.i_mem_r_en;
                end
                if (re) begin
                    e.dat = we ? wd : mem_m[a];
                    e.due = cyc + LAT;
                    pend.push_back(e);
                    m_rd_cnt = sat16(m_rd_cnt);
                end
                if (we) begin
                    mem_m[a] = wd;
                    m_wr_cnt = sat16(m_wr_cnt);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for the next valid pulse and compare its data; n is negedges waited.
    task automatic wait_valid(input string name, input logic [15:0] exp, output int n);
        n = -1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.o_mem_r_valid) begin
                check(name, 32'(bus.o_mem_r_data), 32'(exp));
                n = k;
                break;
            end
        end
        if (n < 0) check({name, "_timeout"}, 32'(bus.o_mem_r_valid), 32'd1);
    endtask

    task automatic core_idle();
        bus.i_mem_r_en = 1'b0;
        bus.i_mem_w_en = 1'b0;
    endtask

    task automatic host_idle();
        bus.i_host_en   = 1'b0;
        bus.i_host_w_en = 1'b0;
        bus.i_host_r_en = 1'b0;
    endtask

    // Directed stimulus with literal expectations.
    initial begin
        int n;
        int vcount;
        logic        sv [7];
        logic [15:0] sd [7];
        bus.i_mem_addr    = '0;
        bus.i_mem_w_data  = '0;
        bus.i_mem_r_en    = 1'b0;
        bus.i_mem_w_en    = 1'b0;
        bus.i_host_en     = 1'b0;
        bus.i_host_addr   = '0;
        bus.i_host_w_data = '0;
        bus.i_host_w_en   = 1'b0;
        bus.i_host_r_en   = 1'b0;
        #1 rst = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("reset_valid", 32'(bus.o_mem_r_valid), 32'd0);
        check("reset_rd_count", 32'(bus.o_rd_count), 32'd0);
        check("reset_wr_count", 32'(bus.o_wr_count), 32'd0);
        tick();
        rst = 1'b0;

        // Preload every word through the host port.
        bus.i_host_en   = 1'b1;
        bus.i_host_w_en = 1'b1;
        for (int i = 0; i < 256; i++) begin
            bus.i_host_addr   = 8'(i);
            bus.i_host_w_data = pat(i);
            tick();
        end
        host_idle();
        tick();
        @(negedge clk);
        check("preload_wr_count", 32'(bus.o_wr_count), 32'd256);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Host write then core read with two-cycle latency.
        bus.i_host_en = 1'b1; bus.i_host_w_en = 1'b1;
        bus.i_host_addr = 8'd3; bus.i_host_w_data = 16'hA5A5;
        tick();
        host_idle();
        bus.i_mem_r_en = 1'b1; bus.i_mem_addr = 16'd3;
        tick();
        core_idle();
        wait_valid("t1_data", 16'hA5A5, n);
        check("t1_latency", 32'(n), 32'd1);
        check("t1_wr_count", 32'(bus.o_wr_count), 32'd1);
        check("t1_rd_count", 32'(bus.o_rd_count), 32'd1);

        // Back-to-back reads of words 0..3.
        tick();
        for (int i = 0; i < 7; i++) begin
            bus.i_mem_r_en = (i < 4);
            bus.i_mem_addr = 16'(i);
            @(negedge clk);
            sv[i] = bus.o_mem_r_valid;
            sd[i] = bus.o_mem_r_data;
            tick();
        end
        core_idle();
        check("t2_gap_before", 32'(sv[1]), 32'd0);
        check("t2_v0", 32'(sv[2]), 32'd1);
        check("t2_d0", 32'(sd[2]), 32'(pat(0)));
        check("t2_v1", 32'(sv[3]), 32'd1);
        check("t2_d1", 32'(sd[3]), 32'(pat(1)));
        check("t2_v2", 32'(sv[4]), 32'd1);
        check("t2_d2", 32'(sd[4]), 32'(pat(2)));
        check("t2_v3", 32'(sv[5]), 32'd1);
        check("t2_d3", 32'(sd[5]), 32'hA5A5);
        check("t2_gap_after", 32'(sv[6]), 32'd0);

        // Simultaneous read and write, same address: write-first.
        bus.i_mem_r_en = 1'b1; bus.i_mem_w_en = 1'b1;
        bus.i_mem_addr = 16'd7; bus.i_mem_w_data = 16'h1234;
        tick();
        core_idle();
        wait_valid("t3_data", 16'h1234, n);
        check("t3_rd_count", 32'(bus.o_rd_count), 32'd6);
        check("t3_wr_count", 32'(bus.o_wr_count), 32'd2);

        // Address wrap.
        tick();
        bus.i_host_en = 1'b1; bus.i_host_w_en = 1'b1;
        bus.i_host_addr = 8'd5; bus.i_host_w_data = 16'hBEEF;
        tick();
        host_idle();
        bus.i_mem_r_en = 1'b1; bus.i_mem_addr = 16'h0105;
        tick();
        core_idle();
        wait_valid("t4_wrap_data", 16'hBEEF, n);
        check("t4_rd_count", 32'(bus.o_rd_count), 32'd7);

        // Core writes dropped while host owns the array.
        tick();
        bus.i_host_en = 1'b1;
        bus.i_mem_w_en = 1'b1; bus.i_mem_addr = 16'd9; bus.i_mem_w_data = 16'hDEAD;
        repeat (3) tick();
        @(negedge clk);
        check("t5_busy", 32'(bus.o_mem_busy), 32'd1);
        check("t5_wr_count", 32'(bus.o_wr_count), 32'd3);
        tick();
        host_idle();
        core_idle();
        bus.i_mem_r_en = 1'b1; bus.i_mem_addr = 16'd9;
        tick();
        core_idle();
        wait_valid("t5_unchanged", pat(9), n);
        check("t5_not_busy", 32'(bus.o_mem_busy), 32'd0);

        // A later write does not disturb a read already in flight.
        tick();
        bus.i_mem_r_en = 1'b1; bus.i_mem_addr = 16'd10;
        tick();
        bus.i_mem_r_en = 1'b0; bus.i_mem_w_en = 1'b1; bus.i_mem_w_data = 16'h0BAD;
        tick();
        core_idle();
        wait_valid("t6_old_data", pat(10), n);
        tick();
        bus.i_mem_r_en = 1'b1; bus.i_mem_addr = 16'd10;
        tick();
        core_idle();
        wait_valid("t6_new_data", 16'h0BAD, n);
        check("t6_wr_count", 32'(bus.o_wr_count), 32'd4);

        // Ownership switch with a core read in flight, followed by a host read.
        tick();
        bus.i_mem_r_en = 1'b1; bus.i_mem_addr = 16'd7;
        tick();
        core_idle();
        bus.i_host_en = 1'b1; bus.i_host_r_en = 1'b1; bus.i_host_addr = 8'd5;
        tick();
        host_idle();
        wait_valid("t7_core_data", 16'h1234, n);
        @(negedge clk);
        check("t7_host_valid", 32'(bus.o_mem_r_valid), 32'd1);
        check("t7_host_data", 32'(bus.o_mem_r_data), 32'hBEEF);
        check("t7_rd_count", 32'(bus.o_rd_count), 32'd12);

        // Reset with a read in flight: the read is lost, array survives.
        tick();
        bus.i_mem_r_en = 1'b1; bus.i_mem_addr = 16'd3;
        tick();
        core_idle();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        vcount = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.o_mem_r_valid) vcount++;
        end
        check("t8_no_valid", 32'(vcount), 32'd0);
        check("t8_rd_count", 32'(bus.o_rd_count), 32'd0);
        check("t8_wr_count", 32'(bus.o_wr_count), 32'd0);
        tick();
        bus.i_mem_r_en = 1'b1; bus.i_mem_addr = 16'd3;
        tick();
        core_idle();
        wait_valid("t8_preserved", 16'hA5A5, n);
        check("t8_rd_after", 32'(bus.o_rd_count), 32'd1);

        repeat (4) tick();
        @(negedge clk);
        check("queue_drained", 32'(pend.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Word-addressed memory responder for the black_bean core's memory port: it answers the core's read and write requests from an internal word array with a fixed, parameterised read latency. A host port lets the bench or a boot loader preload and inspect the array. The block sits directly on the core's memory port and replaces the bare zero-latency storage model behind it.

## Interface
- DATA_WIDTH, 16, word and address width; matches the core's data width.
- DEPTH_LOG2, 8, log2 of array depth in words; the array holds 2**DEPTH_LOG2 words.
- RD_LATENCY, 2, cycles from a sampled read request to o_mem_r_valid; legal range 1..4.
- clk  in  1  the single clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous and active-high.
- i_mem_addr  in  DATA_WIDTH  core word address; only the low DEPTH_LOG2 bits are used.
- i_mem_w_data  in  DATA_WIDTH  core write data.
- i_mem_r_en  in  1  core read request, sampled every cycle.
- i_mem_w_en  in  1  core write request, sampled every cycle.
- o_mem_r_data  out  DATA_WIDTH  read data; valid only while o_mem_r_valid is high.
- o_mem_r_valid  out  1  one-cycle pulse per completed read.
- o_mem_busy  out  1  high while the host owns the array; core requests are dropped.
- i_host_en  in  1  host ownership of the array.
- i_host_addr  in  DEPTH_LOG2  host word address.
- i_host_w_data  in  DATA_WIDTH  host write data.
- i_host_w_en  in  1  host write; with i_host_en low it is ignored.
- i_host_r_en  in  1  host read; returns on the o_mem_r_* outputs with the same latency.
- o_rd_count  out  16  count of accepted reads; saturates at 16'hFFFF.
- o_wr_count  out  16  count of accepted writes; saturates at 16'hFFFF.

## Operation
- Request source select is a mux:
  - i_host_en=1: requests come from the host port.
  - i_host_en=0: requests come from the core port.
  - Requests from the unselected port are ignored entirely and are not counted.
- Write: at the sampling edge the array word at the masked address is updated.
- Read: the array word is captured at the sampling edge into pipeline stage 1. It then shifts through RD_LATENCY-1 further stages, with a valid bit alongside.
- Fully pipelined: one request per cycle, with no stall.
- Read and write in the same cycle are both accepted:
  - Same address: write-first, so the read returns the new data.
  - Different addresses: both proceed independently.
- A write to an address with a read already in flight does not alter that read's data, because the data was captured at issue.
- Address wrap: upper address bits are ignored, so with DEPTH_LOG2=8 address 16'h0105 maps to word 5.
- Counters: incremented by accepted reads and writes (one each for a simultaneous pair) and saturate at 16'hFFFF.
- o_mem_busy = i_host_en, combinational.
- Switching i_host_en while reads are in flight: those reads complete normally and are not cancelled.
- Reset, asynchronous, all outputs 0:
  - Clears pipeline valid and data, o_mem_r_data, o_mem_r_valid and both counters.
  - The array contents are not reset.
  - An in-flight read is lost, and no o_mem_r_valid follows reset release.

## Timing
- A read sampled at edge N gives o_mem_r_valid=1 and data in the cycle after edge N+RD_LATENCY-1. With RD_LATENCY=1, data appears in the cycle after edge N.
- A write is visible to a read issued in the same cycle (write-first) and to any later read.
- Back-to-back reads produce back-to-back valid pulses in issue order.
- Counters update at the same edge as the accepted request.
- o_mem_busy has zero latency from i_host_en.
- No combinational path from inputs to outputs except the i_host_en to o_mem_busy path.

## Structure
- A shared package holds:
  - the DATA_WIDTH default, shared with the core's defines;
  - RD_LATENCY min and max constants;
  - the counter width constant (16).
- Sub-module mem_rd_pipe: a RD_LATENCY-deep valid/data shift register with asynchronous reset. The top level holds the array, write-first bypass, source mux and counters.

## Test plan
- Host writes 16'hA5A5 to address 3 with i_host_en=1, then the core reads address 3 -> with RD_LATENCY=2, o_mem_r_valid pulses two cycles after issue with data 16'hA5A5; o_wr_count=1, o_rd_count=1.
- Core issues reads to addresses 0,1,2,3 on consecutive cycles -> four consecutive valid pulses returning the stored words in order.
- Core sets i_mem_r_en and i_mem_w_en together, address 7, data 16'h1234 -> the read returns 16'h1234; both counters increment by 1.
- Core reads address 16'h0105 after host wrote 16'hBEEF to word 5 -> returns 16'hBEEF.
- i_host_en=1 while the core drives writes -> array unchanged, o_mem_busy=1, o_wr_count unchanged.
- rst asserted one cycle after a read issue -> o_mem_r_valid stays 0 through and after release; counters read 0; array contents are preserved, verified by a subsequent read.
